// File: rtl/buffer_wr_seg_alloc.sv
// ---------------------------------------------------------------------------
// buffer_wr_seg_alloc
//
// Write-side segment allocator for the multichannel packet buffer.
// Incoming packet beats are written to buffer_elem at {segment pointer,
// offset}. Segment pointers come from the free-pointer list via a small
// prefetch queue. A packet may span several segments, and packets may follow
// each other back to back. One used-pointer descriptor is emitted for every
// segment that closes.
//
// Optional feature macro: BUF_WR_STATS_EN
//   When defined, the statistics ports pkt_cnt/seg_cnt/stall_cnt are added.
//   When undefined, those ports and counters are absent.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   s_wdata/s_wvalid/s_wready/s_wlast/s_wsideband
//                    beat stream in (sideband sampled on first beat of packet)
//   fp_rd_req        free-list pop request
//   fp_rd_dout       popped pointer, valid one cycle after fp_rd_req
//   fp_empty         free list empty
//   fp_init_done     free list initialised
//   b_we/b_waddr/b_wdata
//                    buffer write port, {pointer,offset} / {last,data}
//   up_valid/up_desc/up_flow
//                    used-pointer descriptor {last,final offset,pointer}
//   pkt_cnt/seg_cnt/stall_cnt
//                    saturating statistics (BUF_WR_STATS_EN only)
// ---------------------------------------------------------------------------
module buffer_wr_seg_alloc #(
  parameter int DATA_WIDTH     = 1024,
  parameter int BUF_SEG_AW     = 10,
  parameter int SEGMENT_SIZE_W = 8,
  parameter int FLOWS_W        = 3,
  parameter int SB_WIDTH       = FLOWS_W,
  parameter int PREFETCH_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [DATA_WIDTH-1:0]                 s_wdata,
  input  logic                                  s_wvalid,
  output logic                                  s_wready,
  input  logic                                  s_wlast,
  input  logic [SB_WIDTH-1:0]                   s_wsideband,
  output logic                                  fp_rd_req,
  input  logic [BUF_SEG_AW-1:0]                 fp_rd_dout,
  input  logic                                  fp_empty,
  input  logic                                  fp_init_done,
  output logic                                  b_we,
  output logic [BUF_SEG_AW+SEGMENT_SIZE_W-1:0]  b_waddr,
  output logic [DATA_WIDTH:0]                   b_wdata,
  output logic                                  up_valid,
  output logic [SEGMENT_SIZE_W+BUF_SEG_AW:0]    up_desc,
  output logic [FLOWS_W-1:0]                    up_flow
`ifdef BUF_WR_STATS_EN
  ,
  output logic [31:0]                           pkt_cnt,
  output logic [31:0]                           seg_cnt,
  output logic [31:0]                           stall_cnt
`endif
);

  localparam int PF_AW  = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
  localparam int PF_CW  = $clog2(PREFETCH_DEPTH + 1);
  localparam int ADDR_W = BUF_SEG_AW + SEGMENT_SIZE_W;
  localparam int DESC_W = 1 + SEGMENT_SIZE_W + BUF_SEG_AW;

  localparam logic [PF_AW-1:0] PF_LAST    = PF_AW'(PREFETCH_DEPTH - 1);
  localparam logic [PF_CW-1:0] PF_DEPTH_C = PF_CW'(PREFETCH_DEPTH);

  // Ring-pointer advance with explicit wrap so PREFETCH_DEPTH==1 also works.
  function automatic logic [PF_AW-1:0] pf_next(input logic [PF_AW-1:0] ptr);
    logic [PF_AW-1:0] nxt;
    if (ptr == PF_LAST) begin
      nxt = {PF_AW{1'b0}};
    end else begin
      nxt = ptr + {{(PF_AW-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [BUF_SEG_AW-1:0]     pf_mem_q [PREFETCH_DEPTH];
  logic [PF_AW-1:0]          pf_wr_q, pf_wr_d;
  logic [PF_AW-1:0]          pf_rd_q, pf_rd_d;
  logic [PF_CW-1:0]          pf_count_q, pf_count_d;
  logic                      inflight_q;

  logic                      seg_open_q, seg_open_d;
  logic [BUF_SEG_AW-1:0]     cur_ptr_q, cur_ptr_d;
  logic [SEGMENT_SIZE_W-1:0] offset_q, offset_d;
  logic                      pkt_active_q, pkt_active_d;
  logic [FLOWS_W-1:0]        flow_q, flow_d;

  logic                      b_we_q;
  logic [ADDR_W-1:0]         b_waddr_q;
  logic [DATA_WIDTH:0]       b_wdata_q;
  logic                      up_valid_q;
  logic [DESC_W-1:0]         up_desc_q;
  logic [FLOWS_W-1:0]        up_flow_q;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic                      pf_req_s;
  logic                      wready_s;
  logic                      acc_s;
  logic                      pop_s;
  logic                      push_s;
  logic [BUF_SEG_AW-1:0]     beat_ptr_s;
  logic [SEGMENT_SIZE_W-1:0] beat_off_s;
  logic [FLOWS_W-1:0]        beat_flow_s;
  logic                      close_s;

  // Prefetch request, ready and per-beat address/flow selection.
  always_comb begin
    // The pointer already requested last cycle counts against the queue
    // depth, so the queue never overflows. Qualified with rstn so the
    // request is low while reset is held.
    pf_req_s = rstn & fp_init_done & ~fp_empty &
               ((pf_count_q + PF_CW'(inflight_q)) < PF_DEPTH_C);
    // An open segment keeps accepting even if fp_init_done drops;
    // only opening a new segment needs the free list to be up.
    wready_s = seg_open_q | (fp_init_done & (pf_count_q != {PF_CW{1'b0}}));
    acc_s    = s_wvalid & wready_s;
    pop_s    = acc_s & ~seg_open_q;
    push_s   = inflight_q;

    if (seg_open_q) begin
      beat_ptr_s = cur_ptr_q;
      beat_off_s = offset_q;
    end else begin
      beat_ptr_s = pf_mem_q[pf_rd_q];
      beat_off_s = {SEGMENT_SIZE_W{1'b0}};
    end

    // Flow comes from the sideband only on the first beat of a packet.
    if (pkt_active_q) begin
      beat_flow_s = flow_q;
    end else begin
      beat_flow_s = s_wsideband[FLOWS_W-1:0];
    end

    close_s = acc_s & (s_wlast | (beat_off_s == {SEGMENT_SIZE_W{1'b1}}));
  end

  // Next-state for prefetch queue pointers and occupancy.
  always_comb begin
    pf_wr_d    = pf_wr_q;
    pf_rd_d    = pf_rd_q;
    pf_count_d = pf_count_q;
    if (push_s) begin
      pf_wr_d = pf_next(pf_wr_q);
    end else begin
      pf_wr_d = pf_wr_q;
    end
    if (pop_s) begin
      pf_rd_d = pf_next(pf_rd_q);
    end else begin
      pf_rd_d = pf_rd_q;
    end
    case ({push_s, pop_s})
      2'b10:   pf_count_d = pf_count_q + PF_CW'(1);
      2'b01:   pf_count_d = pf_count_q - PF_CW'(1);
      default: pf_count_d = pf_count_q;
    endcase
  end

  // Next-state for the open segment and packet tracking.
  always_comb begin
    seg_open_d   = seg_open_q;
    cur_ptr_d    = cur_ptr_q;
    offset_d     = offset_q;
    pkt_active_d = pkt_active_q;
    flow_d       = flow_q;
    if (acc_s) begin
      cur_ptr_d    = beat_ptr_s;
      flow_d       = beat_flow_s;
      pkt_active_d = ~s_wlast;
      if (close_s) begin
        seg_open_d = 1'b0;
        offset_d   = {SEGMENT_SIZE_W{1'b0}};
      end else begin
        seg_open_d = 1'b1;
        offset_d   = beat_off_s + {{(SEGMENT_SIZE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      seg_open_d   = seg_open_q;
      pkt_active_d = pkt_active_q;
    end
  end

  // Prefetch queue storage, occupancy and in-flight request tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PREFETCH_DEPTH; i++) begin
        pf_mem_q[i] <= {BUF_SEG_AW{1'b0}};
      end
      pf_wr_q    <= {PF_AW{1'b0}};
      pf_rd_q    <= {PF_AW{1'b0}};
      pf_count_q <= {PF_CW{1'b0}};
      inflight_q <= 1'b0;
    end else begin
      if (push_s) begin
        pf_mem_q[pf_wr_q] <= fp_rd_dout;
      end
      pf_wr_q    <= pf_wr_d;
      pf_rd_q    <= pf_rd_d;
      pf_count_q <= pf_count_d;
      inflight_q <= pf_req_s;
    end
  end

  // Open-segment and packet state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_open_q   <= 1'b0;
      cur_ptr_q    <= {BUF_SEG_AW{1'b0}};
      offset_q     <= {SEGMENT_SIZE_W{1'b0}};
      pkt_active_q <= 1'b0;
      flow_q       <= {FLOWS_W{1'b0}};
    end else begin
      seg_open_q   <= seg_open_d;
      cur_ptr_q    <= cur_ptr_d;
      offset_q     <= offset_d;
      pkt_active_q <= pkt_active_d;
      flow_q       <= flow_d;
    end
  end

  // Registered buffer write and descriptor outputs (one cycle after accept).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_we_q     <= 1'b0;
      b_waddr_q  <= {ADDR_W{1'b0}};
      b_wdata_q  <= {(DATA_WIDTH+1){1'b0}};
      up_valid_q <= 1'b0;
      up_desc_q  <= {DESC_W{1'b0}};
      up_flow_q  <= {FLOWS_W{1'b0}};
    end else begin
      b_we_q     <= acc_s;
      up_valid_q <= close_s;
      if (acc_s) begin
        b_waddr_q <= {beat_ptr_s, beat_off_s};
        b_wdata_q <= {s_wlast, s_wdata};
      end
      if (close_s) begin
        // A last beat landing on the final offset yields one descriptor
        // with last=1, since the close condition is evaluated once.
        up_desc_q <= {s_wlast, beat_off_s, beat_ptr_s};
        up_flow_q <= beat_flow_s;
      end
    end
  end

`ifdef BUF_WR_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] seg_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q   <= 32'd0;
      seg_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (close_s && s_wlast && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (close_s && (seg_cnt_q != 32'hFFFF_FFFF)) begin
        seg_cnt_q <= seg_cnt_q + 32'd1;
      end
      if (s_wvalid && !wready_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign seg_cnt   = seg_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign s_wready  = wready_s;
  assign fp_rd_req = pf_req_s;
  assign b_we      = b_we_q;
  assign b_waddr   = b_waddr_q;
  assign b_wdata   = b_wdata_q;
  assign up_valid  = up_valid_q;
  assign up_desc   = up_desc_q;
  assign up_flow   = up_flow_q;

endmodule
